// File: rtl/brlite_svc_queue.sv
// -----------------------------------------------------------------------------
// brlite_svc_queue
//
// Receive-side service buffer between the BrLite router local output port and
// the DMNI network interface. Service messages are accepted from the router
// through a req/ack handshake and stored in a circular FIFO. The head entry is
// presented to the NI, which consumes it with a single-cycle pop pulse.
//
// Parameters:
//   BUFFER_SIZE  FIFO depth in messages (power of 2, >= 2)
//   PTR_W        pointer width, derived from BUFFER_SIZE
//
// Ports:
//   clk_i         clock, rising edge
//   rst_ni        asynchronous active-low reset
//   rx_i          router offers a message (held with data until ack_o)
//   ack_o         one-cycle acceptance pulse to the router
//   ksvc_i        kernel service code        (8 bits)
//   seq_source_i  sequence/source field      (16 bits)
//   producer_i    producer field             (16 bits)
//   payload_i     payload                    (32 bits)
//   svc_rx_o      FIFO non-empty, head entry valid
//   svc_ack_i     pop pulse from the NI
//   svc_data_o    head entry, packed as {ksvc, seq_source, producer, payload}
//                 (brlite_svc_t layout: [71:64] ksvc, [63:48] seq_source,
//                 [47:32] producer, [31:0] payload)
//   count_o       number of stored messages, 0..BUFFER_SIZE
//   full_o        count_o == BUFFER_SIZE
// -----------------------------------------------------------------------------
module brlite_svc_queue #(
  parameter  int BUFFER_SIZE = 8,
  localparam int PTR_W       = $clog2(BUFFER_SIZE)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             rx_i,
  output logic             ack_o,
  input  logic [7:0]       ksvc_i,
  input  logic [15:0]      seq_source_i,
  input  logic [15:0]      producer_i,
  input  logic [31:0]      payload_i,
  output logic             svc_rx_o,
  input  logic             svc_ack_i,
  output logic [71:0]      svc_data_o,
  output logic [PTR_W:0]   count_o,
  output logic             full_o
);

  localparam int DATA_W = 72;
  localparam int CNT_W  = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [BUFFER_SIZE];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ack_q, ack_d;

  logic              full_s;
  logic              empty_s;
  logic              push_s;
  logic              pop_s;
  logic [DATA_W-1:0] in_word_s;

  // Status flags and handshake qualification, all from registered state.
  always_comb begin
    full_s    = (cnt_q == CNT_W'(BUFFER_SIZE));
    empty_s   = (cnt_q == {CNT_W{1'b0}});
    in_word_s = {ksvc_i, seq_source_i, producer_i, payload_i};
    // rx_i is ignored during the ack cycle: the router still holds the
    // message it has just had accepted. Full blocks the push even when a pop
    // happens in the same cycle; the held message goes in one cycle later.
    push_s    = rx_i && !ack_q && !full_s;
    pop_s     = svc_ack_i && !empty_s;
  end

  // Next-state for pointers, occupancy count and the ack pulse.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ack_d    = push_s;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
      ack_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
    end
  end

  // Message storage; cleared on reset so the head output is never X.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < BUFFER_SIZE; i++) begin
        mem_q[i] <= {DATA_W{1'b0}};
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q] <= in_word_s;
    end
  end

  // Outputs are direct views of registered state.
  always_comb begin
    ack_o      = ack_q;
    svc_rx_o   = !empty_s;
    full_o     = full_s;
    count_o    = cnt_q;
    svc_data_o = mem_q[rd_ptr_q];
  end

endmodule

// File: doc/brlite_svc_queue.md
# brlite_svc_queue

Receive-side service buffer between the BrLite router local output port and the DMNI network interface. Accepts service messages from the router through a req/ack handshake, stores them in a FIFO, and presents the head entry to the NI as the `br_svc_rx`/`br_svc_data` pair. The NI consumes the head with a single-cycle pop pulse.

## Interface

Parameters:

- BUFFER_SIZE, 8, FIFO depth in messages. Must be a power of 2 and at least 2.
- PTR_W, $clog2(BUFFER_SIZE), pointer width. Derived; never overridden.

Ports:

- clk_i  input  1  clock; all state updates on rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- rx_i  input  1  router offers a message. Held with data until ack_o is seen.
- ack_o  output  1  one-cycle acceptance pulse to the router.
- ksvc_i  input  8  message kernel service code.
- seq_source_i  input  16  message sequence/source field.
- producer_i  input  16  message producer field.
- payload_i  input  32  message payload.
- svc_rx_o  output  1  FIFO non-empty; head entry valid.
- svc_ack_i  input  1  pop pulse from the NI.
- svc_data_o  output  brlite_svc_t (DMNIPkg)  head entry: ksvc, seq_source, producer, payload.
- count_o  output  PTR_W+1  number of stored messages, 0..BUFFER_SIZE.
- full_o  output  1  count_o == BUFFER_SIZE.

## Operation

- Storage is a circular array of BUFFER_SIZE brlite_svc_t entries with write pointer wr_ptr, read pointer rd_ptr (PTR_W bits each) and count register cnt (PTR_W+1 bits).
- Pointers increment modulo BUFFER_SIZE. Wrap from BUFFER_SIZE-1 to 0 is natural overflow.
- Push condition: rx_i && !ack_o && !full_o, all evaluated on registered values at the start of the cycle.
  - On push, the entry at wr_ptr is written with {ksvc_i, seq_source_i, producer_i, payload_i}.
  - wr_ptr increments and ack_o is set to 1 for exactly one cycle.
- rx_i is ignored while ack_o is high. This prevents a double push of the same message still held by the router.
- Full backpressure:
  - While full_o is high, ack_o is not asserted and the router stalls.
  - full_o blocks the push even when a pop occurs in the same cycle. The push happens the following cycle.
- Pop condition: svc_ack_i && svc_rx_o. On pop, rd_ptr increments.
- svc_ack_i while empty is ignored: no pointer or count change.
- Count update:
  - push only: cnt+1.
  - pop only: cnt-1.
  - push and pop in the same cycle (0 < cnt < BUFFER_SIZE): cnt unchanged, both pointers advance.
- svc_rx_o = (cnt != 0). full_o = (cnt == BUFFER_SIZE). count_o = cnt.
- svc_data_o = array[rd_ptr], read combinationally from registered state. It is stable until the next pop. It is undefined-free: the array is reset to zero.
- No filtering: every offered message is enqueued, in arrival order.

## Timing

- Reset values:
  - ack_o = 0, svc_rx_o = 0, full_o = 0, count_o = 0.
  - svc_data_o = 0; all array entries = 0.
  - wr_ptr = 0, rd_ptr = 0.
- Reset mid-handshake: all state clears immediately. A message pushed but not yet popped is lost. The router re-offers any message not yet acked.
- Push latency: rx_i high at edge N (queue not full) gives:
  - ack_o = 1 during cycle N+1.
  - entry visible at svc_data_o (if queue was empty) and svc_rx_o = 1 during cycle N+1.
- Minimum spacing between pushes is 2 cycles: ack cycle, then the next sample.
- Pop: svc_ack_i high at edge M updates svc_data_o / svc_rx_o in cycle M+1. The NI's registered one-cycle ack pulse pops exactly one entry.
- Full release: a pop at edge M clears full_o in M+1. A held rx_i is accepted at edge M+1, with ack_o high in M+2.

## Test plan

- Single message: reset, offer ksvc=0x12, seq_source=0x0101, producer=0x0203, payload=0xDEADBEEF.
  - Expect ack_o high exactly one cycle.
  - Expect svc_rx_o=1 and svc_data_o matching the offered fields.
  - Pulse svc_ack_i: expect svc_rx_o=0 and count_o=0.
- Fill and backpressure (BUFFER_SIZE=8): offer 9 messages with payload 1..9 and hold rx_i.
  - Expect 8 acks and full_o=1; message 9 gets no ack.
  - One pop: expect ack for payload 9 two cycles later and count_o=8.
- Wrap-around: push/pop 20 messages in mixed order.
  - Expect FIFO order preserved (payloads 1..20 popped in sequence) across pointer wrap.
- Simultaneous push and pop at count_o=3: expect count_o stays 3, head advances, new entry at tail.
- Empty pop and held rx: svc_ack_i pulse at count 0 gives no change.
  - rx_i held high through the ack cycle gives exactly one enqueue per ack.
- Async reset with count_o=5 and ack_o high: all outputs are 0 immediately.
  - Next offered message becomes the head after reset release.
